// File: rtl/sa_tile_scheduler.sv
// ---------------------------------------------------------------------------
// sa_tile_scheduler
//
// Sequences operand beats from an upstream source into a systolic array (SA)
// for one job of cmd_ntiles tiles, each cmd_klen beats long. It counts the
// tiles the SA emits and reports job completion with a single-cycle pulse.
//
// Optional feature: define SA_SCHED_PERF_EN to add the perf_cycles and
// perf_stall counters and their ports.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_klen, cmd_ntiles         beats per tile, tiles per job
//   up_valid/up_ready, up_x/up_k upstream operand stream
//   sa_s_valid/sa_s_ready        SA input handshake, sa_s_last marks tile end
//   sa_sx_data, sa_sk_data       operands passed through to the SA
//   sa_m_valid/ready/last        SA output handshake (monitor only)
//   busy, done, err              status; done and err are one-cycle pulses
//   perf_cycles, perf_stall      (SA_SCHED_PERF_EN only) RUN+DRAIN cycles,
//                                RUN cycles stalled by the SA
// ---------------------------------------------------------------------------
module sa_tile_scheduler #(
  parameter int R   = 4,
  parameter int C   = 8,
  parameter int WX  = 4,
  parameter int WK  = 8,
  parameter int WKL = 16,
  parameter int WT  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [WKL-1:0]    cmd_klen,
  input  logic [WT-1:0]     cmd_ntiles,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [R*WX-1:0]   up_x,
  input  logic [C*WK-1:0]   up_k,
  output logic              sa_s_valid,
  input  logic              sa_s_ready,
  output logic              sa_s_last,
  output logic [R*WX-1:0]   sa_sx_data,
  output logic [C*WK-1:0]   sa_sk_data,
  input  logic              sa_m_valid,
  input  logic              sa_m_ready,
  input  logic              sa_m_last,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef SA_SCHED_PERF_EN
  ,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_stall
`endif
);

  // state  | meaning
  // IDLE   | waiting for a command; illegal commands pulse err and stay here
  // RUN    | streaming operand beats into the SA
  // DRAIN  | all input tiles sent, waiting for remaining output tiles
  // DONE   | one-cycle done pulse, then back to IDLE
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e         state_q, state_d;
  logic [WKL-1:0] klen_q, klen_d;
  logic [WKL-1:0] beat_q, beat_d;
  logic [WT-1:0]  ntiles_q, ntiles_d;
  logic [WT-1:0]  tile_in_q, tile_in_d;
  logic [WT-1:0]  tile_out_q, tile_out_d;
  logic           err_q, err_d;

  logic in_run;
  logic last_beat;
  logic beat_fire;
  logic out_tile;
  logic out_done;

  assign in_run    = (state_q == S_RUN);
  assign last_beat = (beat_q == klen_q - WKL'(1));
  assign beat_fire = in_run && up_valid && sa_s_ready && !rst;
  assign out_tile  = (in_run || state_q == S_DRAIN) && sa_m_valid && sa_m_ready && sa_m_last;

  always_comb begin
    state_d    = state_q;
    klen_d     = klen_q;
    beat_d     = beat_q;
    ntiles_d   = ntiles_q;
    tile_in_d  = tile_in_q;
    tile_out_d = tile_out_q;
    err_d      = 1'b0;
    out_done   = 1'b0;

    // Output count saturates at ntiles so stray extra tiles cannot wrap it.
    if (out_tile && tile_out_q != ntiles_q) tile_out_d = tile_out_q + WT'(1);
    // Uses the next count so the handshake cycle itself completes the job.
    out_done = (tile_out_d == ntiles_q);

    case (state_q)
      S_IDLE: begin
        tile_out_d = tile_out_q;
        if (cmd_valid) begin
          klen_d     = cmd_klen;
          ntiles_d   = cmd_ntiles;
          beat_d     = '0;
          tile_in_d  = '0;
          tile_out_d = '0;
          if (cmd_klen == '0 || cmd_ntiles == '0) err_d = 1'b1;
          else                                    state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (beat_fire) begin
          if (last_beat) begin
            beat_d    = '0;
            tile_in_d = tile_in_q + WT'(1);
            if (tile_in_q == ntiles_q - WT'(1)) state_d = out_done ? S_DONE : S_DRAIN;
          end else begin
            beat_d = beat_q + WKL'(1);
          end
        end
      end
      S_DRAIN: begin
        if (out_done) state_d = S_DONE;
      end
      S_DONE: begin
        tile_out_d = tile_out_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      klen_q     <= '0;
      beat_q     <= '0;
      ntiles_q   <= '0;
      tile_in_q  <= '0;
      tile_out_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      klen_q     <= klen_d;
      beat_q     <= beat_d;
      ntiles_q   <= ntiles_d;
      tile_in_q  <= tile_in_d;
      tile_out_q <= tile_out_d;
      err_q      <= err_d;
    end
  end

  // Outputs are gated by rst so they read inactive throughout reset,
  // including the very first cycle before the state register is loaded.
  assign cmd_ready  = (state_q == S_IDLE) && !rst;
  assign up_ready   = in_run && sa_s_ready && !rst;
  assign sa_s_valid = in_run && up_valid && !rst;
  assign sa_s_last  = in_run && last_beat && !rst;
  assign sa_sx_data = up_x;
  assign sa_sk_data = up_k;
  assign busy       = (state_q != S_IDLE) && !rst;
  assign done       = (state_q == S_DONE) && !rst;
  assign err        = err_q && !rst;

`ifdef SA_SCHED_PERF_EN
  logic [31:0] perf_cycles_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else if (state_q == S_IDLE && cmd_valid) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if ((in_run || state_q == S_DRAIN) && perf_cycles_q != '1)
        perf_cycles_q <= perf_cycles_q + 32'd1;
      if (in_run && up_valid && !sa_s_ready && perf_stall_q != '1)
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_sa_tile_scheduler.sv
module tb_sa_tile_scheduler;
  localparam int R = 4, C = 8, WX = 4, WK = 8, WKL = 16, WT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            cmd_valid = 0, cmd_ready;
  logic [WKL-1:0]  cmd_klen = '0;
  logic [WT-1:0]   cmd_ntiles = '0;
  logic            up_valid = 0, up_ready;
  logic [R*WX-1:0] up_x = '0;
  logic [C*WK-1:0] up_k = '0;
  logic            sa_s_valid, sa_s_ready = 0, sa_s_last;
  logic [R*WX-1:0] sa_sx_data;
  logic [C*WK-1:0] sa_sk_data;
  logic            sa_m_valid = 0, sa_m_ready = 0, sa_m_last = 0;
  logic            busy, done, err;
`ifdef SA_SCHED_PERF_EN
  logic [31:0]     perf_cycles, perf_stall;
`endif

  sa_tile_scheduler #(.R(R), .C(C), .WX(WX), .WK(WK), .WKL(WKL), .WT(WT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_klen(cmd_klen), .cmd_ntiles(cmd_ntiles),
    .up_valid(up_valid), .up_ready(up_ready), .up_x(up_x), .up_k(up_k),
    .sa_s_valid(sa_s_valid), .sa_s_ready(sa_s_ready), .sa_s_last(sa_s_last),
    .sa_sx_data(sa_sx_data), .sa_sk_data(sa_sk_data),
    .sa_m_valid(sa_m_valid), .sa_m_ready(sa_m_ready), .sa_m_last(sa_m_last),
    .busy(busy), .done(done), .err(err)
`ifdef SA_SCHED_PERF_EN
    , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Job-level model: a job is a number of beats (klen*ntiles) in and ntiles
  // tiles out; done appears the cycle after both totals are reached.
  bit     m_active = 0, m_done_now = 0, m_err = 0;
  longint m_klen = 0, m_nt = 0, m_beats = 0, m_outs = 0;

  // DUT-side event log used by the directed checks.
  int cyc = 0, beat_cnt = 0, err_cnt = 0, done_cnt = 0, valid_cnt = 0;
  int last_beat_cyc = 0, out_cyc = 0, done_cyc = 0;
  int last_at[$];

  always @(negedge clk) begin : cmp
    bit in_phase, e_valid, e_uready, e_last, n_err;
    cyc++;
    if (rst) begin
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_up_ready", up_ready, 0);
      chk("rst_s_valid", sa_s_valid, 0);
      chk("rst_s_last", sa_s_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      m_active = 0; m_done_now = 0; m_err = 0;
    end else begin
      in_phase = m_active && !m_done_now && (m_beats < m_klen * m_nt);
      e_valid  = in_phase && up_valid;
      e_uready = in_phase && sa_s_ready;
      e_last   = 0;
      if (in_phase) e_last = ((m_beats % m_klen) == m_klen - 1);
      chk("cmd_ready", cmd_ready, !m_active);
      chk("up_ready", up_ready, e_uready);
      chk("s_valid", sa_s_valid, e_valid);
      chk("s_last", sa_s_last, e_last);
      chk("busy", busy, m_active);
      chk("done", done, m_done_now);
      chk("err", err, m_err);
      if (e_valid) begin
        chk("sx_data", sa_sx_data, up_x);
        chk("sk_data", sa_sk_data, up_k);
      end

      if (sa_s_valid && sa_s_ready) begin
        beat_cnt++;
        if (sa_s_last) begin
          last_at.push_back(beat_cnt);
          last_beat_cyc = cyc;
        end
      end
      if (sa_s_valid) valid_cnt++;
      if (err) err_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (sa_m_valid && sa_m_ready && sa_m_last) out_cyc = cyc;

      n_err = 0;
      if (!m_active) begin
        if (cmd_valid) begin
          m_klen = cmd_klen; m_nt = cmd_ntiles; m_beats = 0; m_outs = 0;
          if (m_klen == 0 || m_nt == 0) n_err = 1;
          else m_active = 1;
        end
      end else if (m_done_now) begin
        m_active = 0; m_done_now = 0;
      end else begin
        if (e_valid && sa_s_ready) m_beats++;
        if (sa_m_valid && sa_m_ready && sa_m_last && m_outs < m_nt) m_outs++;
        if (m_beats == m_klen * m_nt && m_outs == m_nt) m_done_now = 1;
      end
      m_err = n_err;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    up_x = R*WX'($urandom);
    up_k = {$urandom, $urandom};
  endtask

  task automatic send_cmd(input int k, input int n);
    cmd_klen = WKL'(k); cmd_ntiles = WT'(n); cmd_valid = 1;
    step();
    cmd_valid = 0;
  endtask

  task automatic out_tile();
    sa_m_valid = 1; sa_m_ready = 1; sa_m_last = 1;
    step();
    sa_m_valid = 0; sa_m_ready = 0; sa_m_last = 0;
  endtask

  task automatic wait_beats(input int target);
    for (int i = 0; i < 60 && beat_cnt < target; i++) step();
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 30 && done_cnt <= d0; i++) step();
  endtask

  initial begin
    int b0, l0, d0, e0, v0;
    repeat (3) step();
    rst = 0;
    step();
    chk("idle_cmd_ready", cmd_ready, 1);
    chk("idle_busy", busy, 0);

    // klen=3, ntiles=2 with free-flowing data
    b0 = beat_cnt; l0 = last_at.size();
    up_valid = 1; sa_s_ready = 1;
    send_cmd(3, 2);
    wait_beats(b0 + 6);
    step(); step();
    chk("A_beats", beat_cnt - b0, 6);
    chk("A_nlast", last_at.size() - l0, 2);
    if (last_at.size() >= l0 + 2) begin
      chk("A_last1_pos", last_at[l0] - b0, 3);
      chk("A_last2_pos", last_at[l0+1] - b0, 6);
    end
    chk("A_drain_busy", busy, 1);
    chk("A_drain_valid", sa_s_valid, 0);
    out_tile(); step(); step();
    d0 = done_cnt;
    out_tile();
    wait_done(d0);
    chk("A_done_lat", done_cyc - out_cyc, 1);
    chk("A_busy_after", busy, 0);
    step(); step();
    chk("A_done_once", done_cnt - d0, 1);

    // illegal commands
    e0 = err_cnt; v0 = valid_cnt;
    send_cmd(0, 5);
    step();
    send_cmd(2, 0);
    step(); step();
    chk("E_err_cnt", err_cnt - e0, 2);
    chk("E_no_valid", valid_cnt - v0, 0);
    chk("E_cmd_ready", cmd_ready, 1);

    // output tile in IDLE must not count towards the next job
    out_tile();
    step();

    // klen=4, ntiles=1 with SA ready toggling
    b0 = beat_cnt; l0 = last_at.size(); d0 = done_cnt;
    up_valid = 1; sa_s_ready = 0;
    send_cmd(4, 1);
    sa_s_ready = 1;
    for (int i = 0; i < 40 && beat_cnt < b0 + 4; i++) begin
      step();
      sa_s_ready = !sa_s_ready;
    end
    chk("B_beats", beat_cnt - b0, 4);
    chk("B_nlast", last_at.size() - l0, 1);
    if (last_at.size() >= l0 + 1) chk("B_last_pos", last_at[l0] - b0, 4);
`ifdef SA_SCHED_PERF_EN
    chk("B_perf_stall", perf_stall, 3);
`endif
    sa_s_ready = 1;
    step();
    out_tile();
    wait_done(d0);
    chk("B_done", done_cnt - d0, 1);
`ifdef SA_SCHED_PERF_EN
    step();
    chk("B_perf_stall_hold", perf_stall, 3);
`endif

    // reset after 2 of 6 beats
    b0 = beat_cnt; d0 = done_cnt;
    send_cmd(3, 2);
    wait_beats(b0 + 2);
    rst = 1;
    step();
    rst = 0;
    step();
    chk("R_cmd_ready", cmd_ready, 1);
    chk("R_busy", busy, 0);
    chk("R_beats", beat_cnt - b0, 2);
    chk("R_no_done", done_cnt - d0, 0);

    // klen=1, ntiles=3
    b0 = beat_cnt; l0 = last_at.size(); d0 = done_cnt;
    send_cmd(1, 3);
    wait_beats(b0 + 3);
    step();
    chk("D_beats", beat_cnt - b0, 3);
    chk("D_nlast", last_at.size() - l0, 3);
    out_tile(); out_tile(); step();
    chk("D_no_early_done", done_cnt - d0, 0);
    out_tile();
    wait_done(d0);
    chk("D_done_lat", done_cyc - out_cyc, 1);

    // outputs complete while inputs still running: RUN goes straight to DONE
    b0 = beat_cnt; d0 = done_cnt;
    up_valid = 0;
    send_cmd(2, 2);
    out_tile(); out_tile();
    step();
    chk("C_busy", busy, 1);
    up_valid = 1;
    wait_done(d0);
    chk("C_beats", beat_cnt - b0, 4);
    chk("C_done_lat", done_cyc - last_beat_cyc, 1);
    up_valid = 0;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
